// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and detector path.
// State codes, 7-segment glyphs and the pattern length clamp.
package seq_pkg;

  typedef enum logic [1:0] {
    GEN_IDLE  = 2'b00,
    GEN_SHIFT = 2'b01,
    GEN_DONE  = 2'b10
  } gen_state_t;

  // Active-low segments {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_TX    = 7'b0000111;
  localparam logic [6:0] SEG_DONE  = 7'b0100001;
  localparam logic [6:0] SEG_DET   = 7'b0100001;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  // Zero or oversize lengths mean "send the whole word"
  function automatic int unsigned clamp_len(
    input int unsigned len,
    input int unsigned width
  );
    if (len == 0 || len > width)
      return width;
    return len;
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first shift register with length select.
// Keeps a copy of the aligned pattern so repeat passes can reload it.
module seq_shift_reg
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             reload,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  output logic             head,
  output logic             pat_msb,
  output logic             load_msb
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] pat_q;
  logic [WIDTH-1:0] aligned;
  logic [LEN_W:0]   shamt;

  // Left-align so bit [len-1] of data lands in the MSB
  always_comb begin
    shamt   = (LEN_W+1)'(WIDTH) - {1'b0, len};
    aligned = data << shamt;
  end

  // sr_q holds the bits still pending after the one on the wire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      pat_q <= '0;
    end else if (load) begin
      pat_q <= aligned;
      sr_q  <= aligned << 1;
    end else if (reload) begin
      sr_q  <= pat_q << 1;
    end else if (shift) begin
      sr_q  <= sr_q << 1;
    end
  end

  assign head     = sr_q[WIDTH-1];
  assign pat_msb  = pat_q[WIDTH-1];
  assign load_msb = aligned[WIDTH-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: parallel word in, MSB-first bits out.
// Supports repeat passes, hold stalls and a 7-segment status digit.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [RPT_W-1:0] load_repeat,
  input  logic             hold,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done,
  output logic [6:0]       seg_out
);

  gen_state_t       state_q;
  gen_state_t       state_d;
  logic [LEN_W-1:0] len_c;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic             accept;
  logic             adv;
  logic             wrap;
  logic             last;
  logic             sr_shift;
  logic             sr_reload;
  logic             head;
  logic             pat_msb;
  logic             load_msb;

  always_comb begin
    len_c     = LEN_W'(clamp_len(32'(load_len), WIDTH));
    accept    = load_valid && load_ready;
    adv       = (state_q == GEN_SHIFT) && !hold;
    wrap      = adv && (bit_cnt == '0);
    last      = wrap && (rpt_cnt == '0);
    sr_shift  = adv && (bit_cnt != '0);
    sr_reload = wrap && (rpt_cnt != '0);
  end

  seq_shift_reg #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (sr_shift),
    .reload   (sr_reload),
    .data     (load_data),
    .len      (len_c),
    .head     (head),
    .pat_msb  (pat_msb),
    .load_msb (load_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= GEN_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = GEN_IDLE;
    unique case (state_q)
      GEN_IDLE:
        state_d = accept ? GEN_SHIFT : GEN_IDLE;
      GEN_SHIFT:
        state_d = last ? GEN_DONE : GEN_SHIFT;
      GEN_DONE:
        state_d = GEN_IDLE;
      default:
        state_d = GEN_IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    seg_out    = SEG_BLANK;
    unique case (state_q)
      GEN_IDLE: begin
        load_ready = 1'b1;
      end
      GEN_SHIFT: begin
        busy    = 1'b1;
        seg_out = SEG_TX;
      end
      GEN_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        seg_out = SEG_DONE;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  // bit_cnt counts bits left in this pass after the one on the wire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= '0;
      bit_cnt      <= '0;
      rpt_cnt      <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
    end else if (accept) begin
      len_q        <= len_c;
      bit_cnt      <= len_c - LEN_W'(1);
      rpt_cnt      <= load_repeat;
      serial_out   <= load_msb;
      serial_valid <= 1'b1;
    end else if (state_q == GEN_SHIFT) begin
      if (hold) begin
        serial_valid <= 1'b0;
      end else if (bit_cnt != '0) begin
        bit_cnt      <= bit_cnt - LEN_W'(1);
        serial_out   <= head;
        serial_valid <= 1'b1;
      end else if (rpt_cnt != '0) begin
        rpt_cnt      <= rpt_cnt - RPT_W'(1);
        bit_cnt      <= len_q - LEN_W'(1);
        serial_out   <= pat_msb;
        serial_valid <= 1'b1;
      end else begin
        serial_out   <= 1'b0;
        serial_valid <= 1'b0;
      end
    end else begin
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: vector table plus
// hand-written hold, busy-rejection and reset sequences.
module tb_seq_pattern_gen;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic [3:0] load_len;
  logic [3:0] load_repeat;
  logic       hold;
  logic       serial_out;
  logic       serial_valid;
  logic       busy;
  logic       done;
  logic [6:0] seg_out;

  int total;
  int bad;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_TX    = 7'b0000111;
  localparam logic [6:0] S_DONE  = 7'b0100001;

  seq_pattern_gen #(
    .WIDTH (8),
    .LEN_W (4),
    .RPT_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_len     (load_len),
    .load_repeat  (load_repeat),
    .hold         (hold),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .busy         (busy),
    .done         (done),
    .seg_out      (seg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic [3:0]  l;
    logic [3:0]  r;
    logic [31:0] s;
    int          n;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic run_load(input string nm, input vec_t v);
    load_data   = v.d;
    load_len    = v.l;
    load_repeat = v.r;
    load_valid  = 1'b1;
    chk({nm, " ready"}, 32'(load_ready), 32'd1);
    @(negedge clk);
    load_valid = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      chk($sformatf("%s v%0d", nm, k), 32'(serial_valid), 32'd1);
      chk($sformatf("%s b%0d", nm, k), 32'(serial_out),
          32'(v.s[v.n-1-k]));
      if (k == 0)
        chk({nm, " seg_tx"}, 32'(seg_out), 32'(S_TX));
      @(negedge clk);
    end
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " dn_valid"}, 32'(serial_valid), 32'd0);
    chk({nm, " dn_ready"}, 32'(load_ready), 32'd0);
    chk({nm, " seg_done"}, 32'(seg_out), 32'(S_DONE));
    @(negedge clk);
    chk({nm, " idle_ready"}, 32'(load_ready), 32'd1);
    chk({nm, " idle_done"}, 32'(done), 32'd0);
    chk({nm, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic       hv [10];
    logic       ev [10];
    logic       eb [10];
    int         nvalid;
    int         sawdone;
    vec_t       v;

    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    load_valid  = 1'b0;
    load_data   = '0;
    load_len    = '0;
    load_repeat = '0;
    hold        = 1'b0;

    tbl[0] = '{d: 8'h05, l: 4'd3,  r: 4'd0, s: 32'b101,        n: 3};
    tbl[1] = '{d: 8'h05, l: 4'd3,  r: 4'd2, s: 32'b101101101,  n: 9};
    tbl[2] = '{d: 8'hA5, l: 4'd0,  r: 4'd0, s: 32'b10100101,   n: 8};
    tbl[3] = '{d: 8'hA5, l: 4'd15, r: 4'd0, s: 32'b10100101,   n: 8};
    tbl[4] = '{d: 8'h01, l: 4'd1,  r: 4'd3, s: 32'b1111,       n: 4};
    tbl[5] = '{d: 8'hC6, l: 4'd5,  r: 4'd1, s: 32'b0011000110, n: 10};

    @(negedge clk);
    @(negedge clk);
    chk("rst valid", 32'(serial_valid), 32'd0);
    chk("rst out", 32'(serial_out), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst ready", 32'(load_ready), 32'd1);
    chk("rst seg", 32'(seg_out), 32'(S_BLANK));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_load($sformatf("vec%0d", i), tbl[i]);

    // Hold for two cycles after the third bit
    hv = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    ev = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    eb = '{1, 0, 1, 1, 1, 1, 0, 0, 1, 0};
    load_data   = 8'b10110010;
    load_len    = 4'd8;
    load_repeat = 4'd0;
    load_valid  = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold v%0d", i), 32'(serial_valid), 32'(ev[i]));
      chk($sformatf("hold b%0d", i), 32'(serial_out), 32'(eb[i]));
      chk($sformatf("hold nd%0d", i), 32'(done), 32'd0);
      if (serial_valid)
        nvalid++;
      hold = hv[i];
      @(negedge clk);
    end
    chk("hold count", 32'(nvalid), 32'd8);
    chk("hold done", 32'(done), 32'd1);
    @(negedge clk);
    chk("hold idle", 32'(load_ready), 32'd1);

    // Loads offered while busy must be ignored
    load_data   = 8'h05;
    load_len    = 4'd3;
    load_repeat = 4'd0;
    load_valid  = 1'b1;
    @(negedge clk);
    load_data   = 8'hFF;
    load_len    = 4'd8;
    load_repeat = 4'd3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rej ready%0d", i), 32'(load_ready), 32'd0);
      chk($sformatf("rej v%0d", i), 32'(serial_valid), 32'd1);
      chk($sformatf("rej b%0d", i), 32'(serial_out),
          32'(i != 1));
      @(negedge clk);
    end
    chk("rej done", 32'(done), 32'd1);
    chk("rej dn_ready", 32'(load_ready), 32'd0);
    @(negedge clk);
    load_valid = 1'b0;
    chk("rej idle_ready", 32'(load_ready), 32'd1);
    chk("rej idle_valid", 32'(serial_valid), 32'd0);
    @(negedge clk);
    chk("rej no_send", 32'(serial_valid), 32'd0);
    chk("rej no_busy", 32'(busy), 32'd0);

    // Reset during the second bit of a three-pass load
    load_data   = 8'h05;
    load_len    = 4'd3;
    load_repeat = 4'd2;
    load_valid  = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    chk("mid b1", 32'(serial_out), 32'd0);
    chk("mid v1", 32'(serial_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid rst valid", 32'(serial_valid), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst ready", 32'(load_ready), 32'd1);
    chk("mid rst seg", 32'(seg_out), 32'(S_BLANK));
    @(negedge clk);
    rst = 1'b0;
    sawdone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || serial_valid)
        sawdone++;
      @(negedge clk);
    end
    chk("mid no_done", 32'(sawdone), 32'd0);

    v = tbl[0];
    run_load("post_rst", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
